// File: rtl/onehot_encoder_serial.sv
// rtl/onehot_encoder_serial.sv - serialising 8-to-3 encoder: emits the index of every set bit of a request vector
// Optional macro ONEHOT_STRICT_EN: reject multi-hot vectors with an err pulse instead of serialising them.
module onehot_encoder_serial #(
    parameter bit PRIORITY_MSB = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    output logic       y_valid,
    input  logic       y_ready,
    output logic [2:0] y,
    output logic       y_last,
    output logic       err
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t     state, state_nxt;
    logic [7:0] pending, pending_nxt;
    logic       err_nxt;
    logic       in_ready_q;
    logic [2:0] pri_idx;
    logic       single;
`ifdef ONEHOT_STRICT_EN
    logic       a_multi;

    assign a_multi = (a & (a - 8'd1)) != 8'd0;
`endif

    // Later loop iterations win, so the scan direction selects the priority end.
    always_comb begin
        pri_idx = 3'd0;
        if (PRIORITY_MSB) begin
            for (int i = 0; i < 8; i++)
                if (pending[i]) pri_idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (pending[i]) pri_idx = 3'(i);
        end
    end

    assign single = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 8'h00;
            err        <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            err        <= err_nxt;
            in_ready_q <= (state_nxt == IDLE);
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (a == 8'h00)
                        err_nxt = 1'b1;
`ifdef ONEHOT_STRICT_EN
                    else if (a_multi)
                        err_nxt = 1'b1;
`endif
                    else begin
                        pending_nxt = a;
                        state_nxt   = EMIT;
                    end
                end
            end
            EMIT: begin
                if (y_ready) begin
                    pending_nxt = pending & ~(8'd1 << pri_idx);
                    if (single) begin
                        state_nxt   = IDLE;
                        pending_nxt = 8'h00;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                pending_nxt = 8'h00;
            end
        endcase
    end

    always_comb begin
        in_ready = in_ready_q;
        y_valid  = (state == EMIT);
        y        = (state == EMIT) ? pri_idx : 3'd0;
        y_last   = (state == EMIT) && single;
    end

endmodule

// File: tb/tb_onehot_encoder_serial.sv
// tb/tb_onehot_encoder_serial.sv - randomized bench for onehot_encoder_serial, both priority orders side by side
module tb_onehot_encoder_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic       y_ready;
    logic       in_ready0, y_valid0, y_last0, err0;
    logic       in_ready1, y_valid1, y_last1, err1;
    logic [2:0] y0, y1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    onehot_encoder_serial #(.PRIORITY_MSB(1'b0)) u_lo (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a),
        .y_valid(y_valid0), .y_ready(y_ready), .y(y0), .y_last(y_last0), .err(err0)
    );

    onehot_encoder_serial #(.PRIORITY_MSB(1'b1)) u_hi (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a),
        .y_valid(y_valid1), .y_ready(y_ready), .y(y1), .y_last(y_last1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vld0"}, y_valid0, 0);
        chk({tag, "_vld1"}, y_valid1, 0);
        chk({tag, "_y0"}, y0, 0);
        chk({tag, "_last0"}, y_last0, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready0 && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_wait", in_ready0, 1);
        chk("in_ready_wait1", in_ready1, 1);
    endtask

    // stall_mode: 0 = y_ready high, 1 = random, 2 = hold low for the first 5 cycles
    task automatic send(input logic [7:0] vec, input int stall_mode);
        int lo[$];
        int hi[$];
        int k = 0;
        int cyc = 0;
        int stalls = 0;
        bit reject;
        wait_ready();
        for (int i = 0; i < 8; i++)
            if (vec[i]) begin
                lo.push_back(i);
                hi.push_front(i);
            end
        reject = (lo.size() == 0);
`ifdef ONEHOT_STRICT_EN
        reject = reject || (lo.size() > 1);
`endif
        in_valid = 1'b1;
        a        = vec;
        step();
        in_valid = 1'b0;
        a        = 8'($urandom);
        if (reject) begin
            chk("rej_err0", err0, 1);
            chk("rej_err1", err1, 1);
            chk_idle("rej");
            step();
            chk("rej_err_clr0", err0, 0);
            chk("rej_err_clr1", err1, 0);
            chk("rej_ready", in_ready0, 1);
            chk_idle("rej_after");
        end else begin
            while (k < lo.size() && cyc < 200) begin
                chk("emit_vld0", y_valid0, 1);
                chk("emit_vld1", y_valid1, 1);
                chk("emit_y_lo", y0, lo[k]);
                chk("emit_y_hi", y1, hi[k]);
                chk("emit_last0", y_last0, (k == lo.size() - 1) ? 1 : 0);
                chk("emit_last1", y_last1, (k == lo.size() - 1) ? 1 : 0);
                chk("emit_rdy0", in_ready0, 0);
                chk("emit_err0", err0, 0);
                if (lo.size() == 1) chk("roundtrip", 8'd1 << y0, vec);
                case (stall_mode)
                    0:       y_ready = 1'b1;
                    1:       y_ready = ($urandom_range(0, 2) != 0);
                    default: y_ready = (stalls >= 5);
                endcase
                if (!y_ready) stalls++;
                step();
                if (y_ready) k++;
                cyc++;
            end
            chk("emit_done", k, lo.size());
            y_ready = 1'b1;
            chk_idle("post");
            chk("post_ready0", in_ready0, 1);
            chk("post_ready1", in_ready1, 1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'hFF;
        y_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", in_ready0, 0);
            chk("rst_err", err0, 0);
            chk_idle("rst");
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        chk("rel_ready", in_ready0, 1);
        chk_idle("rel");
        step();
        chk_idle("rel2");

        for (int i = 0; i < 8; i++) send(8'd1 << i, 0);
        send(8'hA5, 0);
        send(8'h18, 2);
        send(8'h00, 0);

        a = 8'hxx;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("noval_ready", in_ready0, 1);
            chk("noval_err", err0, 0);
            chk_idle("noval");
        end

        for (int i = 0; i < 30; i++) send(8'($urandom), 1);

        wait_ready();
        in_valid = 1'b1;
        a        = 8'hF0;
        step();
        in_valid = 1'b0;
`ifdef ONEHOT_STRICT_EN
        chk("midrst_err", err0, 1);
        chk_idle("midrst_rej");
        step();
`else
        chk("midrst_y_lo", y0, 4);
        chk("midrst_y_hi", y1, 7);
        chk("midrst_vld", y_valid0, 1);
        rst = 1'b1;
        step();
        chk("midrst_ready", in_ready0, 0);
        chk_idle("midrst");
        rst = 1'b0;
        step();
`endif
        chk("midrst_rel_ready", in_ready0, 1);
        chk_idle("midrst_rel");
        step();
        chk_idle("midrst_rel2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_serial.md
Name: onehot_encoder_serial

Overview:
- 8-to-3 encoder; the inverse of the team's registered 3-to-8 decoder.
- Accepts an 8-bit request vector through a valid/ready handshake.
- Emits the 3-bit index of every set bit, one index per output handshake, in priority order.
- Flags zero (empty) input vectors on an error pulse.
- Sits upstream of the decoder so that y of this block can drive the decoder's a input.

Parameters:
- PRIORITY_MSB, default 0: 0 = lowest set index emitted first; 1 = highest set index emitted first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a is valid this cycle.
- in_ready  output  1  block can accept a vector.
- a  input  8  request vector; ignored (may be X) when in_valid=0.
- y_valid  output  1  y holds a valid index.
- y_ready  input  1  downstream accepts y.
- y  output  3  encoded index of the current set bit.
- y_last  output  1  y is the final index for the current vector.
- err  output  1  one-cycle pulse: zero vector (or multi-hot in strict mode) rejected.

Behaviour:
- Clocking and reset
  - One clock, clk. Reset is synchronous and active-high on rst, sampled at the rising edge.
  - While rst=1 at an edge: state=IDLE, pending=8'h00, in_ready=0, y_valid=0, y=3'd0, y_last=0, err=0.
  - First cycle after rst deasserts: in_ready=1.
- Output paths
  - All outputs derive only from registers; no combinational path from a, in_valid or y_ready to any output.
  - in_ready = (state==IDLE) && !rst_seen; in practice it depends on state only.
- State IDLE
  - in_ready=1, y_valid=0.
  - Accept occurs when in_valid && in_ready at an edge.
  - Accept with a==0: stay IDLE; err=1 for the next cycle only.
  - Accept with a!=0: pending<=a; go to EMIT.
- State EMIT
  - in_ready=0, y_valid=1.
  - y = index of the priority set bit of pending:
    - PRIORITY_MSB=0: lowest set index.
    - PRIORITY_MSB=1: highest set index.
  - y_last=1 iff pending has exactly one bit set.
  - On y_valid && y_ready: clear that bit in pending.
    - If y_last: go to IDLE; pending becomes 0; y and y_last return to 0.
    - Else: stay in EMIT; the next index is presented the following cycle.
- Backpressure: while y_ready=0, y, y_valid and y_last hold stable; pending is unchanged.
- Latency and throughput
  - Vector accepted at edge k gives y_valid=1 from edge k+1.
  - A one-hot vector takes 2 cycles (accept, emit) with y_ready tied high.
  - A vector with n bits set occupies n+1 cycles minimum.
  - No overlap: the next vector is accepted only in IDLE, so in_ready=1 on the cycle after the y_last handshake.
- Reset mid-operation: rst in EMIT discards pending immediately and emits no further indices.
- y value when idle: y is 3'd0 whenever y_valid=0.

Optional Feature:
- Macro: ONEHOT_STRICT_EN.
- Defined: an accepted a with more than one bit set is rejected. State stays IDLE, err pulses for 1 cycle, and no output is produced. Only one-hot vectors reach EMIT, so y_last is always 1.
- Not defined: multi-hot vectors are serialised as described under Behaviour. err pulses only for zero vectors.

Test Plan:
- Reset held 3 cycles with in_valid=1, a=8'hFF -> in_ready=0, y_valid=0, y=0, y_last=0, err=0 throughout. After release, in_ready=1 and nothing was captured.
- One-hot sweep: a=8'h01..8'h80 (one per transaction), y_ready=1 -> y=0..7 in order, each with y_last=1, y_valid one cycle after accept. Also check the decoder(y) round-trip equals a.
- Multi-hot a=8'hA5, y_ready=1:
  - PRIORITY_MSB=0 -> y sequence 0,2,5,7; y_last only on 7.
  - PRIORITY_MSB=1 -> 7,5,2,0; y_last on 0.
  - in_ready=0 during all 4 index cycles.
- Backpressure: a=8'h18, y_ready=0 for 5 cycles -> y=3 held with y_valid=1 and y_last=0. Then y_ready=1 -> y=4 with y_last=1, then IDLE.
- Zero vector, and X on a while in_valid=0:
  - a=8'h00 accepted -> err=1 for exactly one cycle; no y_valid.
  - a=8'hxx with in_valid=0 -> no state change.
- Reset mid-EMIT: a=8'hF0 accepted, rst asserted after first index -> next cycle y_valid=0, pending cleared; after release in_ready=1. Under ONEHOT_STRICT_EN, a=8'hF0 -> err pulse, no output.
